// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, data width, line levels and parity helper.
// Used by uart_tx and intended for reuse by the matching receiver.
package uart_pkg;

    localparam int DATA_W = 8;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;
    localparam logic LINE_STOP  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Even parity of the byte, inverted when odd parity is selected.
    function automatic logic parity_bit(input logic [DATA_W-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: reload sets CLK_DIV-1, counts down to 0 and holds there.
// tick is high while the counter is 0, i.e. on the last cycle of a bit.
module uart_baud_gen #(
    parameter int CLK_DIV = 174
) (
    input  logic clk,
    input  logic resetn,
    input  logic reload,
    output logic tick
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_r;

    // Down-counter with synchronous reset and reload on every bit boundary.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_r <= CNT_ZERO;
        end else if (reload) begin
            cnt_r <= CNT_TOP;
        end else if (cnt_r != CNT_ZERO) begin
            cnt_r <= cnt_r - CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign tick = (cnt_r == CNT_ZERO);

endmodule

// File: rtl/uart_tx.sv
// 8N1/8N2 UART transmitter with valid/ready byte input and registered serial output.
// Define UART_TX_PARITY_EN to insert a parity bit (even, or odd with PARITY_ODD=1) after data bit 7.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 174,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic              SYS_CLK,
    input  logic              RESETN,
    input  logic [DATA_W-1:0] TX_DATA,
    input  logic              TX_VALID,
    output logic              TX_READY,
    output logic              USB_UART_RXD,
    output logic              TX_BUSY
);

    localparam bit PARAMS_OK = (CLK_DIV >= 2) && (CLK_DIV <= 65535) &&
                               ((STOP_BITS == 1) || (STOP_BITS == 2)) &&
                               ((PARITY_ODD == 0) || (PARITY_ODD == 1));
    localparam logic       LAST_STOP = 1'(STOP_BITS - 1);
    localparam logic [2:0] LAST_DATA = 3'd7;

    if (!PARAMS_OK) begin : g_param_check
        $fatal(1, "uart_tx: illegal CLK_DIV, STOP_BITS or PARITY_ODD");
    end

    uart_state_e       state_r;
    logic [DATA_W-1:0] shift_r;
    logic [2:0]        bit_idx_r;
    logic              stop_idx_r;
    logic              line_r;
    logic              busy_r;
`ifdef UART_TX_PARITY_EN
    logic              parity_r;
`endif

    logic tick_s;
    logic last_stop_s;
    logic ready_s;
    logic accept_s;
    logic reload_s;

    assign last_stop_s = (state_r == ST_STOP) && tick_s && (stop_idx_r == LAST_STOP);
    assign ready_s     = RESETN && ((state_r == ST_IDLE) || last_stop_s);
    assign accept_s    = TX_VALID && ready_s;
    // Counter rests at 0 while idle; it is only reloaded inside a frame or on accept.
    assign reload_s    = accept_s || (tick_s && (state_r != ST_IDLE) && !last_stop_s);

    uart_baud_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_baud_gen (
        .clk    (SYS_CLK),
        .resetn (RESETN),
        .reload (reload_s),
        .tick   (tick_s)
    );

    // Frame sequencer: shift register, bit/stop indices and registered line/busy outputs.
    always_ff @(posedge SYS_CLK) begin
        if (!RESETN) begin
            state_r    <= ST_IDLE;
            shift_r    <= {DATA_W{1'b0}};
            bit_idx_r  <= 3'd0;
            stop_idx_r <= 1'b0;
            line_r     <= LINE_IDLE;
            busy_r     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_r   <= 1'b0;
`endif
        end else if (accept_s) begin
            state_r    <= ST_START;
            shift_r    <= TX_DATA;
            bit_idx_r  <= 3'd0;
            stop_idx_r <= 1'b0;
            line_r     <= LINE_START;
            busy_r     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_r   <= parity_bit(TX_DATA, 1'(PARITY_ODD));
`endif
        end else if (tick_s) begin
            case (state_r)
                ST_IDLE: begin
                    line_r <= LINE_IDLE;
                    busy_r <= 1'b0;
                end
                ST_START: begin
                    state_r <= ST_DATA;
                    line_r  <= shift_r[0];
                    shift_r <= {1'b0, shift_r[DATA_W-1:1]};
                end
                ST_DATA: begin
                    if (bit_idx_r == LAST_DATA) begin
                        bit_idx_r <= 3'd0;
`ifdef UART_TX_PARITY_EN
                        state_r   <= ST_PARITY;
                        line_r    <= parity_r;
`else
                        state_r    <= ST_STOP;
                        line_r     <= LINE_STOP;
                        stop_idx_r <= 1'b0;
`endif
                    end else begin
                        bit_idx_r <= bit_idx_r + 3'd1;
                        line_r    <= shift_r[0];
                        shift_r   <= {1'b0, shift_r[DATA_W-1:1]};
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    state_r    <= ST_STOP;
                    line_r     <= LINE_STOP;
                    stop_idx_r <= 1'b0;
                end
`endif
                ST_STOP: begin
                    if (stop_idx_r == LAST_STOP) begin
                        state_r    <= ST_IDLE;
                        line_r     <= LINE_IDLE;
                        busy_r     <= 1'b0;
                        stop_idx_r <= 1'b0;
                    end else begin
                        stop_idx_r <= stop_idx_r + 1'b1;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    line_r     <= LINE_IDLE;
                    busy_r     <= 1'b0;
                    bit_idx_r  <= 3'd0;
                    stop_idx_r <= 1'b0;
                end
            endcase
        end else begin
            state_r <= state_r;
        end
    end

    assign TX_READY     = ready_s;
    assign USB_UART_RXD = line_r;
    assign TX_BUSY      = busy_r;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: unit 0 is CLK_DIV=4/1 stop/even, unit 1 is CLK_DIV=4/2 stop/odd.
// Builds with or without UART_TX_PARITY_EN; expected parity bits are hand-computed per vector.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic       clk = 1'b0;
    logic       resetn;
    logic [1:0] valid;
    logic [7:0] data [2];
    wire  [1:0] ready;
    wire  [1:0] rxd;
    wire  [1:0] busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uart_tx #(.CLK_DIV(4), .STOP_BITS(1), .PARITY_ODD(0)) dut_a (
        .SYS_CLK      (clk),
        .RESETN       (resetn),
        .TX_DATA      (data[0]),
        .TX_VALID     (valid[0]),
        .TX_READY     (ready[0]),
        .USB_UART_RXD (rxd[0]),
        .TX_BUSY      (busy[0])
    );

    uart_tx #(.CLK_DIV(4), .STOP_BITS(2), .PARITY_ODD(1)) dut_b (
        .SYS_CLK      (clk),
        .RESETN       (resetn),
        .TX_DATA      (data[1]),
        .TX_VALID     (valid[1]),
        .TX_READY     (ready[1]),
        .USB_UART_RXD (rxd[1]),
        .TX_BUSY      (busy[1])
    );

    typedef struct {
        int         unit;
        logic [7:0] tx;
        logic [7:0] late;
        logic       par;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_ready(input int u);
        int n;
        n = 0;
        while (ready[u] !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", 32'(ready[u]), 32'd1);
    endtask

    // Sends one byte; frame cycle c (1-based after accept) is sampled at the negedge of that cycle.
    task automatic run_frame(input int u, input logic [7:0] d, input logic [7:0] late,
                             input logic par, input logic chain);
        int         nstop;
        int         len;
        logic [11:0] bits;
        nstop = (u == 0) ? 1 : 2;
        len   = (9 + P + nstop) * 4;
        bits  = 12'hFFF;
        bits[0]   = 1'b0;
        bits[8:1] = d;
`ifdef UART_TX_PARITY_EN
        bits[9]   = par;
`else
        if (par === 1'bx) bits[0] = 1'b0;
`endif
        wait_ready(u);
        data[u]  = d;
        valid[u] = 1'b1;
        @(posedge clk);
        #1;
        data[u]  = late;
        valid[u] = chain;
        for (int c = 0; c < len; c++) begin
            @(negedge clk);
            check($sformatf("line u%0d d%0h c%0d", u, d, c), 32'(rxd[u]), 32'(bits[c / 4]));
            check($sformatf("busy u%0d c%0d", u, c), 32'(busy[u]), 32'd1);
            check($sformatf("ready u%0d c%0d", u, c), 32'(ready[u]), 32'(c == len - 1));
        end
        if (!chain) begin
            @(negedge clk);
            check("post_line", 32'(rxd[u]), 32'd1);
            check("post_busy", 32'(busy[u]), 32'd0);
            check("post_ready", 32'(ready[u]), 32'd1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        int   bad_line;
        int   bad_busy;
        vecs[0] = '{0, 8'h55, 8'h55, 1'b0};
        vecs[1] = '{0, 8'hA3, 8'hA3, 1'b0};
        vecs[2] = '{0, 8'hC3, 8'h00, 1'b0};
        vecs[3] = '{0, 8'h00, 8'hFF, 1'b0};
        vecs[4] = '{0, 8'h01, 8'h80, 1'b1};
        vecs[5] = '{1, 8'h81, 8'h81, 1'b1};
        vecs[6] = '{1, 8'hA3, 8'h5C, 1'b1};
        vecs[7] = '{1, 8'h07, 8'h07, 1'b0};

        resetn  = 1'b0;
        valid   = 2'b00;
        data[0] = 8'h00;
        data[1] = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_line_a", 32'(rxd[0]), 32'd1);
        check("rst_line_b", 32'(rxd[1]), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(ready), 32'd0);
        resetn = 1'b1;
        #1;
        check("first_ready", 32'(ready), 32'd3);

        bad_line = 0;
        bad_busy = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rxd !== 2'b11) bad_line++;
            if (busy !== 2'b00) bad_busy++;
        end
        check("idle_line_glitches", 32'(bad_line), 32'd0);
        check("idle_busy_glitches", 32'(bad_busy), 32'd0);

        for (int i = 0; i < 8; i++) begin
            run_frame(vecs[i].unit, vecs[i].tx, vecs[i].late, vecs[i].par, 1'b0);
        end

        // Back-to-back: valid stays high, second byte accepted in the last stop cycle.
        run_frame(0, 8'h00, 8'hFF, 1'b0, 1'b1);
        run_frame(0, 8'hFF, 8'hFF, 1'b0, 1'b0);

        // Reset during data bit 3 of 0xF0, then a clean 0x0F frame.
        wait_ready(0);
        data[0]  = 8'hF0;
        valid[0] = 1'b1;
        @(posedge clk);
        #1;
        valid[0] = 1'b0;
        repeat (18) @(negedge clk);
        check("pre_rst_bit3", 32'(rxd[0]), 32'd0);
        check("pre_rst_busy", 32'(busy[0]), 32'd1);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        check("abort_line", 32'(rxd[0]), 32'd1);
        check("abort_busy", 32'(busy[0]), 32'd0);
        check("abort_ready", 32'(ready[0]), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        check("rel_ready", 32'(ready[0]), 32'd1);
        check("rel_line", 32'(rxd[0]), 32'd1);
        run_frame(0, 8'h0F, 8'h0F, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
